// File: rtl/trap_sequencer_if.sv
// Commit-side event/CSR bus of the trap sequencer; master drives events,
// slave is the sequencer that owns the trap CSRs.
interface trap_sequencer_if #(
  parameter int XLEN = 64
);
  logic            inst_valid;
  logic [15:0]     exc_vec;
  logic [XLEN-1:0] exc_pc;
  logic [XLEN-1:0] exc_tval;
  logic            ret_valid;
  logic            ret_is_mret;
  logic [11:0]     mip;
  logic [11:0]     mie;
  logic [11:0]     mideleg;
  logic [15:0]     medeleg;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] stvec;
  logic            csr_wen;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic            ack;
  logic            busy;
  logic [1:0]      priv_mode;
  logic [XLEN-1:0] mstatus;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] sepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] scause;
  logic [XLEN-1:0] mtval;
  logic [XLEN-1:0] stval;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;

  modport master (
    output inst_valid, exc_vec, exc_pc, exc_tval, ret_valid, ret_is_mret,
           mip, mie, mideleg, medeleg, mtvec, stvec, csr_wen, csr_addr, csr_wdata,
    input  ack, busy, priv_mode, mstatus, mepc, sepc, mcause, scause, mtval, stval,
           redirect_valid, redirect_target
  );

  modport slave (
    input  inst_valid, exc_vec, exc_pc, exc_tval, ret_valid, ret_is_mret,
           mip, mie, mideleg, medeleg, mtvec, stvec, csr_wen, csr_addr, csr_wdata,
    output ack, busy, priv_mode, mstatus, mepc, sepc, mcause, scause, mtval, stval,
           redirect_valid, redirect_target
  );
endinterface

// File: rtl/trap_sequencer.sv
// Trap entry / xRET exit sequencer: owns the trap CSRs and privilege mode,
// takes one event per instruction boundary and issues one redirect for it.
module trap_sequencer #(
  parameter int XLEN = 64
) (
  input logic             clk,
  input logic             reset,
  trap_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SAVE, REDIRECT} state_t;
  typedef enum logic [1:0] {EV_TRAP, EV_MRET, EV_SRET} kind_t;

  localparam logic [1:0]  PRV_U    = 2'b00;
  localparam logic [1:0]  PRV_S    = 2'b01;
  localparam logic [1:0]  PRV_M    = 2'b11;
  localparam logic [11:0] A_MSTAT  = 12'h300;
  localparam logic [11:0] A_MEPC   = 12'h341;
  localparam logic [11:0] A_SEPC   = 12'h141;
  localparam logic [11:0] INT_IMPL = 12'hAAA;
  localparam logic [15:0] EXC_IMPL = 16'hBBFF;
  localparam logic [3:0]  INT_PRI [6]  = '{4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5};
  localparam logic [3:0]  EXC_PRI [14] = '{4'd3, 4'd12, 4'd1, 4'd2, 4'd0, 4'd8, 4'd9,
                                           4'd11, 4'd6, 4'd4, 4'd15, 4'd13, 4'd7, 4'd5};

  state_t          state;
  logic            busy_r, rdr_vld;
  logic [1:0]      priv, mpp;
  logic            sie, mie_b, spie, mpie, spp, tsr;
  logic [XLEN-1:0] mepc, sepc, mcause, scause, mtval, stval;

  kind_t           lat_kind;
  logic            lat_to_s, lat_intr;
  logic [3:0]      lat_cause;
  logic [XLEN-1:0] lat_tval, lat_pc, lat_target;

  logic [11:0]     pend, int_en;
  logic            m_int_on, s_int_on, int_any, exc_any, ret_bad, ev_any, ack_c;
  logic            deleg, to_s;
  logic [3:0]      int_sel, exc_sel;
  kind_t           ev_kind;
  logic            ev_intr;
  logic [3:0]      ev_cause;
  logic [XLEN-1:0] ev_tval, tvec, vec_off, ev_target, mstatus_w;

  // Event arbitration: enabled interrupt > exception > xRET.
  always_comb begin
    pend     = bus.mip & bus.mie;
    m_int_on = (priv != PRV_M) || mie_b;
    s_int_on = (priv == PRV_U) || ((priv == PRV_S) && sie);
    for (int i = 0; i < 12; i++)
      int_en[i] = pend[i] && INT_IMPL[i] && (bus.mideleg[i] ? s_int_on : m_int_on);
    int_any = |int_en;
    int_sel = '0;
    for (int k = 5; k >= 0; k--)
      if (int_en[INT_PRI[k]]) int_sel = INT_PRI[k];

    exc_any = |(bus.exc_vec & EXC_IMPL);
    exc_sel = '0;
    for (int k = 13; k >= 0; k--)
      if (bus.exc_vec[EXC_PRI[k]]) exc_sel = EXC_PRI[k];

    ret_bad = bus.ret_is_mret ? (priv != PRV_M)
                              : ((priv == PRV_U) || ((priv == PRV_S) && tsr));

    ev_kind  = EV_TRAP;
    ev_intr  = 1'b0;
    ev_cause = '0;
    ev_tval  = '0;
    ev_any   = 1'b1;
    if (int_any) begin
      ev_intr  = 1'b1;
      ev_cause = int_sel;
    end else if (exc_any) begin
      ev_cause = exc_sel;
      ev_tval  = bus.exc_tval;
    end else if (bus.ret_valid && ret_bad) begin
      ev_cause = 4'd2;
    end else if (bus.ret_valid) begin
      ev_kind = bus.ret_is_mret ? EV_MRET : EV_SRET;
    end else begin
      ev_any = 1'b0;
    end

    deleg   = ev_intr ? bus.mideleg[ev_cause] : bus.medeleg[ev_cause];
    to_s    = deleg && (priv != PRV_M);
    tvec    = to_s ? bus.stvec : bus.mtvec;
    vec_off = (ev_intr && (tvec[1:0] == 2'b01)) ? XLEN'({ev_cause, 2'b00}) : '0;
    case (ev_kind)
      EV_MRET: ev_target = mepc;
      EV_SRET: ev_target = sepc;
      default: ev_target = {tvec[XLEN-1:2], 2'b00} + vec_off;
    endcase

    ack_c = (state == IDLE) && bus.inst_valid && ev_any;
  end

  always_comb begin
    mstatus_w        = '0;
    mstatus_w[1]     = sie;
    mstatus_w[3]     = mie_b;
    mstatus_w[5]     = spie;
    mstatus_w[7]     = mpie;
    mstatus_w[8]     = spp;
    mstatus_w[12:11] = mpp;
    mstatus_w[22]    = tsr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy_r     <= 1'b0;
      rdr_vld    <= 1'b0;
      priv       <= PRV_M;
      {sie, mie_b, spie, mpie, spp, tsr} <= '0;
      mpp        <= PRV_U;
      mepc       <= '0;
      sepc       <= '0;
      mcause     <= '0;
      scause     <= '0;
      mtval      <= '0;
      stval      <= '0;
      lat_kind   <= EV_TRAP;
      lat_to_s   <= 1'b0;
      lat_intr   <= 1'b0;
      lat_cause  <= '0;
      lat_tval   <= '0;
      lat_pc     <= '0;
      lat_target <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ack_c) begin
            lat_kind   <= ev_kind;
            lat_to_s   <= to_s;
            lat_intr   <= ev_intr;
            lat_cause  <= ev_cause;
            lat_tval   <= ev_tval;
            lat_pc     <= bus.exc_pc & ~XLEN'(1);
            lat_target <= ev_target;
            busy_r     <= 1'b1;
            state      <= SAVE;
          end else if (bus.csr_wen) begin
            case (bus.csr_addr)
              A_MSTAT: begin
                sie   <= bus.csr_wdata[1];
                mie_b <= bus.csr_wdata[3];
                spie  <= bus.csr_wdata[5];
                mpie  <= bus.csr_wdata[7];
                spp   <= bus.csr_wdata[8];
                tsr   <= bus.csr_wdata[22];
                // MPP=10 is a reserved mode; the old value is kept.
                if (bus.csr_wdata[12:11] != 2'b10) mpp <= bus.csr_wdata[12:11];
              end
              A_MEPC:  mepc <= bus.csr_wdata & ~XLEN'(1);
              A_SEPC:  sepc <= bus.csr_wdata & ~XLEN'(1);
              default: ;
            endcase
          end
        end
        SAVE: begin
          case (lat_kind)
            EV_MRET: begin
              mie_b <= mpie;
              mpie  <= 1'b1;
              priv  <= mpp;
              mpp   <= PRV_U;
            end
            EV_SRET: begin
              sie  <= spie;
              spie <= 1'b1;
              priv <= {1'b0, spp};
              spp  <= 1'b0;
            end
            default: begin
              if (lat_to_s) begin
                sepc   <= lat_pc;
                scause <= {lat_intr, {(XLEN-5){1'b0}}, lat_cause};
                stval  <= lat_tval;
                spie   <= sie;
                sie    <= 1'b0;
                spp    <= priv[0];
                priv   <= PRV_S;
              end else begin
                mepc   <= lat_pc;
                mcause <= {lat_intr, {(XLEN-5){1'b0}}, lat_cause};
                mtval  <= lat_tval;
                mpie   <= mie_b;
                mie_b  <= 1'b0;
                mpp    <= priv;
                priv   <= PRV_M;
              end
            end
          endcase
          rdr_vld <= 1'b1;
          state   <= REDIRECT;
        end
        REDIRECT: begin
          rdr_vld <= 1'b0;
          busy_r  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack             = ack_c;
  assign bus.busy            = busy_r;
  assign bus.priv_mode       = priv;
  assign bus.mstatus         = mstatus_w;
  assign bus.mepc            = mepc;
  assign bus.sepc            = sepc;
  assign bus.mcause          = mcause;
  assign bus.scause          = scause;
  assign bus.mtval           = mtval;
  assign bus.stval           = stval;
  assign bus.redirect_valid  = rdr_vld;
  assign bus.redirect_target = lat_target;
endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: cycle-accurate event model checked every
// cycle, plus literal expectations after each scenario.
module tb_trap_sequencer;
  localparam int XLEN = 64;
  localparam logic [63:0] MS_MASK = 64'h4019AA;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  trap_sequencer_if #(.XLEN(XLEN)) tif ();
  trap_sequencer #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(tif));

  int checks = 0;
  int errors = 0;
  int dut_rdr = 0;
  logic [63:0] last_target = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int IPRI [6]  = '{11, 3, 7, 9, 1, 5};
  int EPRI [14] = '{3, 12, 1, 2, 0, 8, 9, 11, 6, 4, 15, 13, 7, 5};

  int          ph;
  logic [1:0]  mp, np;
  logic [63:0] mms, mmepc, msepc, mmcause, mscause, mmtval, mstval;
  logic [63:0] nms, nmepc, nsepc, nmcause, nscause, nmtval, nstval, ntarget;
  logic [11:0] pend;
  logic [63:0] tv, tvec, cv;
  logic [1:0]  keep;
  bit          hit, intr, tos;
  int          kind, cause;

  always @(negedge clk) begin
    if (tif.redirect_valid) dut_rdr++;
    if (reset) begin
      ph = 0; mp = 2'b11; mms = '0; mmepc = '0; msepc = '0;
      mmcause = '0; mscause = '0; mmtval = '0; mstval = '0;
    end else begin
      chk("m_priv", tif.priv_mode, mp);
      chk("m_mstatus", tif.mstatus, mms);
      chk("m_mepc", tif.mepc, mmepc);
      chk("m_sepc", tif.sepc, msepc);
      chk("m_mcause", tif.mcause, mmcause);
      chk("m_scause", tif.scause, mscause);
      chk("m_mtval", tif.mtval, mmtval);
      chk("m_stval", tif.stval, mstval);
      if (ph == 0) begin
        hit = 0; intr = 0; kind = 0; cause = 0; tv = '0;
        if (tif.inst_valid) begin
          pend = tif.mip & tif.mie;
          foreach (IPRI[k])
            if (!hit && pend[IPRI[k]] &&
                (tif.mideleg[IPRI[k]] ? (mp == 2'b00 || (mp == 2'b01 && mms[1]))
                                      : (mp != 2'b11 || mms[3]))) begin
              hit = 1; intr = 1; cause = IPRI[k];
            end
          foreach (EPRI[k])
            if (!hit && tif.exc_vec[EPRI[k]]) begin
              hit = 1; cause = EPRI[k]; tv = tif.exc_tval;
            end
          if (!hit && tif.ret_valid) begin
            hit = 1; cause = 2;
            if (tif.ret_is_mret && mp == 2'b11) kind = 1;
            else if (!tif.ret_is_mret && (mp == 2'b11 || (mp == 2'b01 && !mms[22]))) kind = 2;
          end
        end
        chk("m_ack", tif.ack, hit);
        chk("m_busy", tif.busy, 1'b0);
        chk("m_rv", tif.redirect_valid, 1'b0);
        if (hit) begin
          nms = mms; np = mp; nmepc = mmepc; nsepc = msepc;
          nmcause = mmcause; nscause = mscause; nmtval = mmtval; nstval = mstval;
          if (kind == 1) begin
            nms[3] = mms[7]; nms[7] = 1'b1; np = mms[12:11]; nms[12:11] = 2'b00;
            ntarget = mmepc;
          end else if (kind == 2) begin
            nms[1] = mms[5]; nms[5] = 1'b1; np = {1'b0, mms[8]}; nms[8] = 1'b0;
            ntarget = msepc;
          end else begin
            tos = (intr ? tif.mideleg[cause] : tif.medeleg[cause]) && mp != 2'b11;
            cv = intr ? ((64'h1 << 63) | 64'(cause)) : 64'(cause);
            if (tos) begin
              nsepc = tif.exc_pc & ~64'h1; nscause = cv; nstval = tv;
              nms[5] = mms[1]; nms[1] = 1'b0; nms[8] = mp[0]; np = 2'b01;
              tvec = tif.stvec;
            end else begin
              nmepc = tif.exc_pc & ~64'h1; nmcause = cv; nmtval = tv;
              nms[7] = mms[3]; nms[3] = 1'b0; nms[12:11] = mp; np = 2'b11;
              tvec = tif.mtvec;
            end
            ntarget = (tvec & ~64'h3) + ((intr && tvec[1:0] == 2'b01) ? 64'(4 * cause) : 64'h0);
          end
          ph = 1;
        end else if (tif.csr_wen) begin
          case (tif.csr_addr)
            12'h300: begin
              keep = (tif.csr_wdata[12:11] == 2'b10) ? mms[12:11] : tif.csr_wdata[12:11];
              mms = tif.csr_wdata & MS_MASK;
              mms[12:11] = keep;
            end
            12'h341: mmepc = tif.csr_wdata & ~64'h1;
            12'h141: msepc = tif.csr_wdata & ~64'h1;
            default: ;
          endcase
        end
      end else if (ph == 1) begin
        chk("m_ack", tif.ack, 1'b0);
        chk("m_busy", tif.busy, 1'b1);
        chk("m_rv", tif.redirect_valid, 1'b0);
        mms = nms; mp = np; mmepc = nmepc; msepc = nsepc;
        mmcause = nmcause; mscause = nscause; mmtval = nmtval; mstval = nstval;
        ph = 2;
      end else begin
        chk("m_ack", tif.ack, 1'b0);
        chk("m_busy", tif.busy, 1'b1);
        chk("m_rv", tif.redirect_valid, 1'b1);
        chk("m_target", tif.redirect_target, ntarget);
        last_target = tif.redirect_target;
        ph = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr_req;
    tif.inst_valid = 1'b0; tif.exc_vec = '0; tif.ret_valid = 1'b0;
    tif.ret_is_mret = 1'b0; tif.csr_wen = 1'b0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [63:0] d);
    @(posedge clk); #1;
    tif.csr_wen = 1'b1; tif.csr_addr = a; tif.csr_wdata = d;
    @(posedge clk); #1;
    tif.csr_wen = 1'b0;
  endtask

  // Holds a request until ack (bounded), then lets the sequence finish.
  task automatic fire(input logic [15:0] ev, input logic rv, input logic rm,
                      input logic [63:0] pc, input logic [63:0] tv, input logic exp_ack);
    bit got;
    @(posedge clk); #1;
    tif.inst_valid = 1'b1; tif.exc_vec = ev; tif.ret_valid = rv;
    tif.ret_is_mret = rm; tif.exc_pc = pc; tif.exc_tval = tv;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (tif.ack) got = 1;
    end
    chk("ack_seen", got, exp_ack);
    @(posedge clk); #1;
    clr_req;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic to_u;
    csr_wr(12'h300, 64'h0);
    csr_wr(12'h341, 64'h80000100);
    fire(16'h0, 1'b1, 1'b1, 64'h0, 64'h0, 1'b1);
    chk("to_u_priv", tif.priv_mode, 2'b00);
  endtask

  int rc;

  initial begin
    clr_req;
    tif.exc_pc = '0; tif.exc_tval = '0; tif.mip = '0; tif.mie = '0;
    tif.mideleg = '0; tif.medeleg = '0; tif.mtvec = 64'h80000000;
    tif.stvec = 64'h80002000; tif.csr_addr = '0; tif.csr_wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_priv", tif.priv_mode, 2'b11);
    chk("rst_mstatus", tif.mstatus, 64'h0);
    chk("rst_busy", tif.busy, 1'b0);
    chk("rst_mcause", tif.mcause, 64'h0);

    // 1: ecall from U to M
    to_u;
    fire(16'h0100, 1'b0, 1'b0, 64'h80001004, 64'h0, 1'b1);
    chk("t1_target", last_target, 64'h80000000);
    chk("t1_mepc", tif.mepc, 64'h80001004);
    chk("t1_mcause", tif.mcause, 64'd8);
    chk("t1_mpp", tif.mstatus[12:11], 2'b00);
    chk("t1_mie", tif.mstatus[3], 1'b0);
    chk("t1_priv", tif.priv_mode, 2'b11);

    // 2: delegated ecall from U to S
    tif.medeleg = 16'h0100;
    to_u;
    fire(16'h0100, 1'b0, 1'b0, 64'h80001004, 64'h0, 1'b1);
    chk("t2_scause", tif.scause, 64'd8);
    chk("t2_sepc", tif.sepc, 64'h80001004);
    chk("t2_spp", tif.mstatus[8], 1'b0);
    chk("t2_priv", tif.priv_mode, 2'b01);
    chk("t2_target", last_target, 64'h80002000);
    chk("t2_mcause", tif.mcause, 64'd8);

    // 3: exception priority
    tif.medeleg = '0;
    fire(16'h100E, 1'b0, 1'b0, 64'h80003000, 64'hDEAD, 1'b1);
    chk("t3_mcause_a", tif.mcause, 64'd3);
    chk("t3_mtval_a", tif.mtval, 64'hDEAD);
    chk("t3_mpp_a", tif.mstatus[12:11], 2'b01);
    fire(16'h0006, 1'b0, 1'b0, 64'h80003004, 64'hBEEF, 1'b1);
    chk("t3_mcause_b", tif.mcause, 64'd1);
    chk("t3_mtval_b", tif.mtval, 64'hBEEF);

    // 4: vectored M interrupt, then masked by MIE=0
    csr_wr(12'h300, 64'h8);
    tif.mtvec = 64'h80000001; tif.mip = 12'h888; tif.mie = 12'h888;
    fire(16'h0, 1'b0, 1'b0, 64'h80003100, 64'h77, 1'b1);
    chk("t4_mcause", tif.mcause, 64'h800000000000000B);
    chk("t4_mtval", tif.mtval, 64'h0);
    chk("t4_target", last_target, 64'h8000002C);
    chk("t4_mstatus", tif.mstatus, 64'h1880);
    fire(16'h0, 1'b0, 1'b0, 64'h80003200, 64'h0, 1'b0);
    tif.mip = '0;

    // 5: MRET to S, SRET to U, illegal SRET in U
    csr_wr(12'h300, 64'h880);
    csr_wr(12'h341, 64'h80004000);
    fire(16'h0, 1'b1, 1'b1, 64'h80003300, 64'h0, 1'b1);
    chk("t5_priv_m", tif.priv_mode, 2'b01);
    chk("t5_mstatus_m", tif.mstatus, 64'h88);
    chk("t5_target_m", last_target, 64'h80004000);
    fire(16'h0, 1'b1, 1'b0, 64'h80003400, 64'h0, 1'b1);
    chk("t5_priv_s", tif.priv_mode, 2'b00);
    chk("t5_target_s", last_target, 64'h80001004);
    fire(16'h0, 1'b1, 1'b0, 64'h80005000, 64'h5555, 1'b1);
    chk("t5_mcause_ill", tif.mcause, 64'd2);
    chk("t5_mtval_ill", tif.mtval, 64'h0);
    chk("t5_mepc_ill", tif.mepc, 64'h80005000);
    chk("t5_target_ill", last_target, 64'h80000000);
    chk("t5_mstatus_ill", tif.mstatus, 64'hA0);

    // 6: reset during SAVE aborts without redirect
    @(posedge clk); #1;
    tif.inst_valid = 1'b1; tif.exc_vec = 16'h0100; tif.exc_pc = 64'h80006000;
    rc = 0;
    for (int i = 0; i < 8 && rc == 0; i++) begin
      @(negedge clk);
      if (tif.ack) rc = 1;
    end
    chk("t6_ack", rc, 1);
    @(posedge clk); #1;
    reset = 1'b1; clr_req;
    rc = dut_rdr;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t6_priv", tif.priv_mode, 2'b11);
    chk("t6_busy", tif.busy, 1'b0);
    chk("t6_rv", tif.redirect_valid, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_no_redirect", dut_rdr, rc);
    csr_wr(12'h300, 64'hFFFFFFFFFFFFFFFF);
    chk("t6_ms_mask", tif.mstatus, 64'h4019AA);
    csr_wr(12'h300, 64'h1000);
    chk("t6_mpp_keep", tif.mstatus, 64'h1800);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Multi-cycle controller that owns the trap-related machine/supervisor CSR state and sequences trap entry and xRET exit.
- Arbitrates interrupts against exceptions by fixed priority, resolves delegation, and updates the affected CSRs and privilege mode.
- Issues a single front-end redirect per accepted event.
- Sits between the commit stage and the CSR file, replacing per-field ad-hoc update logic.

Parameters:
XLEN, 64, datapath width; only 64 supported.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
inst_valid  in  1  instruction boundary; events sampled only when high
exc_vec  in  16  raised exception causes (bit n = cause n)
exc_pc  in  XLEN  PC of faulting/returning instruction
exc_tval  in  XLEN  trap value for exceptions
ret_valid  in  1  xRET request
ret_is_mret  in  1  1=MRET, 0=SRET
mip  in  12  pending interrupts
mie  in  12  interrupt enables
mideleg  in  12  interrupt delegation
medeleg  in  16  exception delegation
mtvec  in  XLEN  M trap vector
stvec  in  XLEN  S trap vector
csr_wen  in  1  software write strobe
csr_addr  in  12  0x300 mstatus, 0x341 mepc, 0x141 sepc; other addresses ignored
csr_wdata  in  XLEN  write data
ack  out  1  event accepted this cycle
busy  out  1  sequence in progress
priv_mode  out  2  current privilege (00 U, 01 S, 11 M)
mstatus  out  XLEN  managed bits only; all others read 0
mepc, sepc, mcause, scause, mtval, stval  out  XLEN  trap CSRs
redirect_valid  out  1  one-cycle redirect pulse
redirect_target  out  XLEN  redirect PC

Behaviour:
- Reset: state IDLE; priv_mode=11; mstatus, epcs, causes, tvals all 0; ack, busy, redirect_valid 0. Reset mid-sequence aborts the sequence; no redirect is issued.
- Managed mstatus bits: SIE[1], MIE[3], SPIE[5], MPIE[7], SPP[8], MPP[12:11], TSR[22]. A software write of MPP=10 keeps the old MPP. Bit 0 of mepc/sepc always reads 0.
- FSM IDLE -> SAVE -> REDIRECT -> IDLE.
  - IDLE: when inst_valid and an event is present, ack=1 (combinational) and the event is latched.
  - SAVE: CSRs and priv_mode are written at the end of the cycle.
  - REDIRECT: redirect_valid=1 with redirect_target.
  - busy=1 in SAVE and REDIRECT. Inputs are ignored while busy; upstream holds its request until ack.
  - Latency: ack at cycle T, redirect at T+2, CSR values visible from T+2.
- Event priority: enabled interrupt > exception > ret_valid. If exc_vec and ret_valid are both present, the exception is taken and ret_valid is dropped.
- A csr_wen in the same cycle as ack, or while busy, is dropped.
- Interrupt enable: pend = mip & mie.
  - Cause i targets S if mideleg[i], else M.
  - M-target interrupts are enabled if priv<M, or priv==M and MIE.
  - S-target interrupts are enabled if priv==U, or priv==S and SIE. They are never taken in M.
  - Priority among enabled interrupts: 11, 3, 7, 9, 1, 5.
  - Interrupt cause value = (1<<63) | i; tval = 0.
- Exception priority: 3, 12, 1, 2, 0, 8, 9, 11, 6, 4, 15, 13, 7, 5.
- Delegation: go to S iff deleg[cause] and priv!=M.
- Trap to M:
  - mepc=exc_pc, mcause, mtval updated.
  - MPIE=MIE, MIE=0, MPP=priv, priv=M.
  - Target = mtvec&~3, plus 4*cause if mtvec[1:0]==01 and the event is an interrupt.
- Trap to S: same rules using sepc, scause, stval, SPIE/SIE, SPP=priv[0], priv=S, stvec.
- MRET (priv==M): MIE=MPIE, MPIE=1, priv=MPP, MPP=00, target=mepc.
- SRET (priv>=S and not (priv==S and TSR)): SIE=SPIE, SPIE=1, priv={0,SPP}, SPP=0, target=sepc.
- Illegal xRET: MRET below M, SRET in U, or SRET with TSR in S is converted to illegal-instruction trap cause 2 with tval=0, delegated per the normal rules.
- Only the highest-priority event is handled; the others remain visible to upstream for later.

Test Plan:
1. priv=U, medeleg=0, exc_vec=0x0100 (ecall 8), exc_pc=0x80001004, mtvec=0x80000000 -> ack at T, redirect at T+2 to 0x80000000; mepc=0x80001004, mcause=8, MPP=00, MIE=0, priv=11.
2. priv=U, medeleg[8]=1, stvec=0x80002000, same ecall -> scause=8, sepc=0x80001004, SPP=0, priv=01, redirect 0x80002000; mcause unchanged.
3. exc_vec=0x100E (bits 1, 2, 3, 12) -> cause 3 selected; then exc_vec=0x0006 -> cause 1.
4. priv=M, MIE=1, mip=mie=0x888, mtvec=0x80000001 -> mcause=0x800000000000000B, mtval=0, target 0x8000002C; with MIE=0 -> no ack.
5. MRET with MPP=01, MPIE=1, mepc=0x80004000 -> priv=01, MIE=1, MPIE=1, MPP=00, redirect 0x80004000. SRET in U -> mcause=2.
6. Reset asserted during SAVE -> next cycle priv=11, busy=0, no redirect pulse. csr_wen to mstatus with MPP=10 -> MPP unchanged.
